// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the multiplier and adder datapath.
// Stage structures carry operands between pipeline registers.
package fp16_pkg;

  localparam int EXP_W     = 5;
  localparam int MAN_W     = 10;
  localparam int BIAS      = 15;
  localparam int EXP_MAX   = 31;
  localparam int EXP_SUM_W = 7;
  localparam int PROD_W    = 2 * (MAN_W + 1);

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_INF  = 16'h7C00;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp16_unpacked_t;

  // Special-result class decided in the first stage and carried to packing.
  typedef enum logic [1:0] {
    SPC_NONE = 2'd0,
    SPC_QNAN = 2'd1,
    SPC_INF  = 2'd2,
    SPC_ZERO = 2'd3
  } fp16_special_e;

  typedef struct packed {
    logic                 sign;
    fp16_special_e        special;
    logic [EXP_SUM_W-1:0] exp;
    logic [PROD_W-1:0]    prod;
  } mul_s1_t;

  typedef struct packed {
    logic                 sign;
    fp16_special_e        special;
    logic [EXP_SUM_W-1:0] exp;
    logic [MAN_W-1:0]     man;
    logic                 guard;
    logic                 sticky;
  } mul_s2_t;

  // Subnormal encodings (exp == 0) are treated as zero.
  function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] v);
    fp16_unpacked_t u;
    u.sign    = v[15];
    u.exp     = v[14:10];
    u.man     = v[9:0];
    u.is_zero = (v[14:10] == '0);
    u.is_inf  = (v[14:10] == '1) && (v[9:0] == '0);
    u.is_nan  = (v[14:10] == '1) && (v[9:0] != '0);
    return u;
  endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Final multiplier stage logic: rounding, range limiting, special select, packing.
// Build option MUL_ROUND_EN selects round-to-nearest-even; otherwise truncation.
import fp16_pkg::*;

module fp16_round_pack (
  input  logic                 i_sign,
  input  fp16_special_e        i_special,
  input  logic [EXP_SUM_W-1:0] i_exp,
  input  logic [MAN_W-1:0]     i_man,
  input  logic                 i_guard,
  input  logic                 i_sticky,
  output logic [15:0]          o_result
);

  localparam logic signed [EXP_SUM_W-1:0] EXP_MAX_S = EXP_SUM_W'(EXP_MAX);

  logic                        w_inc;
  logic [MAN_W:0]              w_man_sum;
  logic                        w_carry;
  logic signed [EXP_SUM_W-1:0] w_exp_fin;
  logic [MAN_W-1:0]            w_man_fin;

`ifdef MUL_ROUND_EN
  assign w_inc = i_guard & (i_sticky | i_man[0]);
`else
  logic w_unused_rnd;
  assign w_unused_rnd = i_guard ^ i_sticky;
  assign w_inc        = 1'b0;
`endif

  // A rounding carry out of the mantissa renormalises to 1.0 x 2^(exp+1).
  assign w_man_sum = {1'b0, i_man} + {{MAN_W{1'b0}}, w_inc};
  assign w_carry   = w_man_sum[MAN_W];
  assign w_exp_fin = $signed(i_exp) + $signed({{(EXP_SUM_W-1){1'b0}}, w_carry});
  assign w_man_fin = w_carry ? '0 : w_man_sum[MAN_W-1:0];

  always_comb begin
    o_result = '0;
    case (i_special)
      SPC_QNAN: o_result = FP16_QNAN;
      SPC_INF:  o_result = {i_sign, FP16_INF[14:0]};
      SPC_ZERO: o_result = {i_sign, 15'h0000};
      default: begin
        if (w_exp_fin >= EXP_MAX_S) begin
          o_result = {i_sign, FP16_INF[14:0]};
        end else if (w_exp_fin <= $signed(EXP_SUM_W'(0))) begin
          o_result = {i_sign, 15'h0000};
        end else begin
          o_result = {i_sign, w_exp_fin[EXP_W-1:0], w_man_fin};
        end
      end
    endcase
  end

endmodule

// File: rtl/mod_mul.sv
// Three-stage pipelined fp16 multiplier: unpack/multiply, normalise, round/pack.
// Rounding mode selected by the MUL_ROUND_EN macro (see fp16_round_pack).
import fp16_pkg::*;

module mod_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_A,
  input  logic [15:0] in_B,
  input  logic        in_En,
  output logic [15:0] out_Out,
  output logic        out_Ready
);

  // Handshake: in_En qualifies in_A/in_B on every rising edge (no backpressure);
  // out_Ready is high for exactly one cycle per accepted pair, 3 edges later, in order.

  fp16_unpacked_t              w_a;
  fp16_unpacked_t              w_b;
  mul_s1_t                     w_s1_next;
  mul_s2_t                     w_s2_next;
  logic [15:0]                 w_result;
  logic signed [EXP_SUM_W-1:0] w_exp_sum;

  mul_s1_t     r_s1;
  logic        r_s1_valid;
  mul_s2_t     r_s2;
  logic        r_s2_valid;
  logic [15:0] r_out;
  logic        r_ready;

  assign w_a = fp16_unpack(in_A);
  assign w_b = fp16_unpack(in_B);

  assign w_exp_sum = $signed({2'b00, w_a.exp}) + $signed({2'b00, w_b.exp})
                   - $signed(EXP_SUM_W'(BIAS));

  // Stage 1: sign, biased exponent sum, 11x11 significand product, class.
  always_comb begin
    w_s1_next.sign    = w_a.sign ^ w_b.sign;
    w_s1_next.exp     = w_exp_sum;
    w_s1_next.prod    = PROD_W'({1'b1, w_a.man}) * PROD_W'({1'b1, w_b.man});
    w_s1_next.special = SPC_NONE;
    if (w_a.is_nan || w_b.is_nan ||
        (w_a.is_inf && w_b.is_zero) || (w_a.is_zero && w_b.is_inf)) begin
      w_s1_next.special = SPC_QNAN;
    end else if (w_a.is_inf || w_b.is_inf) begin
      w_s1_next.special = SPC_INF;
    end else if (w_a.is_zero || w_b.is_zero) begin
      w_s1_next.special = SPC_ZERO;
    end
  end

  // Stage 2: product lies in [1,4); shift by one when it reached [2,4).
  always_comb begin
    w_s2_next.sign    = r_s1.sign;
    w_s2_next.special = r_s1.special;
    if (r_s1.prod[PROD_W-1]) begin
      w_s2_next.exp    = r_s1.exp + EXP_SUM_W'(1);
      w_s2_next.man    = r_s1.prod[PROD_W-2 -: MAN_W];
      w_s2_next.guard  = r_s1.prod[PROD_W-2-MAN_W];
      w_s2_next.sticky = |r_s1.prod[PROD_W-3-MAN_W:0];
    end else begin
      w_s2_next.exp    = r_s1.exp;
      w_s2_next.man    = r_s1.prod[PROD_W-3 -: MAN_W];
      w_s2_next.guard  = r_s1.prod[MAN_W-1];
      w_s2_next.sticky = |r_s1.prod[MAN_W-2:0];
    end
  end

  fp16_round_pack u_round_pack (
    .i_sign    (r_s2.sign),
    .i_special (r_s2.special),
    .i_exp     (r_s2.exp),
    .i_man     (r_s2.man),
    .i_guard   (r_s2.guard),
    .i_sticky  (r_s2.sticky),
    .o_result  (w_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= '0;
      r_s1_valid <= 1'b0;
      r_s2       <= '0;
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_s1_valid <= in_En;
      r_s2_valid <= r_s1_valid;
      r_ready    <= r_s2_valid;
      if (in_En) begin
        r_s1 <= w_s1_next;
      end
      if (r_s1_valid) begin
        r_s2 <= w_s2_next;
      end
      // out_Out only changes when a new product is presented.
      if (r_s2_valid) begin
        r_out <= w_result;
      end
    end
  end

  assign out_Out   = r_out;
  assign out_Ready = r_ready;

endmodule

// File: tb/tb_mod_mul.sv
// Directed-vector bench for mod_mul with an expected-value queue and a monitor.
// Honours MUL_ROUND_EN for the rounding-sensitive vector.
module tb_mod_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_A = 16'h0000;
  logic [15:0] in_B = 16'h0000;
  logic        in_En = 1'b0;
  logic [15:0] out_Out;
  logic        out_Ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] exp_q[$];
  int          lat_q[$];

`ifdef MUL_ROUND_EN
  localparam logic [15:0] RND_EXP = 16'h3E02;
`else
  localparam logic [15:0] RND_EXP = 16'h3E01;
`endif

  mod_mul dut (
    .clk       (clk),
    .rst       (rst),
    .in_A      (in_A),
    .in_B      (in_B),
    .in_En     (in_En),
    .out_Out   (out_Out),
    .out_Ready (out_Ready)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Driver: present one operand pair for one edge and record the expectation.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
    @(negedge clk);
    in_A  = a;
    in_B  = b;
    in_En = 1'b1;
    exp_q.push_back(e);
    lat_q.push_back(cyc + 3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_En = 1'b0;
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && out_Ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: out_Out=%h with no pending operation (cycle %0d)",
                 out_Out, cyc);
      end else begin
        logic [15:0] e;
        int          c;
        e = exp_q.pop_front();
        c = lat_q.pop_front();
        check16("product", out_Out, e);
        check_int("latency", cyc, c);
      end
    end
  end

  logic [15:0] vec_a[10] = '{16'h3E00, 16'hC000, 16'h3C01, 16'h7BFF, 16'h0400,
                             16'h7C00, 16'h7E01, 16'hFC00, 16'h8000, 16'h8400};
  logic [15:0] vec_b[10] = '{16'h3E00, 16'h4200, 16'h3E00, 16'h4000, 16'h3800,
                             16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h3800};
  logic [15:0] vec_e[10] = '{16'h4080, 16'hC600, RND_EXP,  16'h7C00, 16'h0000,
                             16'h7E00, 16'h7E00, 16'hFC00, 16'h8000, 16'h8000};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check16("reset_out", out_Out, 16'h0000);
    check16("reset_ready", {15'h0, out_Ready}, 16'h0000);
    rst = 1'b0;
    idle(1);

    // Basic product, then out_Out must hold once out_Ready drops
    issue(16'h4000, 16'h4200, 16'h4600);
    idle(5);
    check16("hold_out", out_Out, 16'h4600);
    check16("hold_ready", {15'h0, out_Ready}, 16'h0000);

    // Isolated directed vectors
    for (int i = 0; i < 10; i++) begin
      issue(vec_a[i], vec_b[i], vec_e[i]);
      idle(1);
    end
    idle(5);

    // Streaming: back-to-back pairs, results in order
    issue(16'h4000, 16'h4200, 16'h4600);
    issue(16'h3E00, 16'h3E00, 16'h4080);
    issue(16'hC000, 16'h4200, 16'hC600);
    issue(16'h7BFF, 16'h4000, 16'h7C00);
    idle(6);
    check_int("stream_drained", exp_q.size(), 0);

    // Reset mid-flight: both operations must be discarded
    issue(16'h4000, 16'h4200, 16'h4600);
    issue(16'h3E00, 16'h3E00, 16'h4080);
    @(negedge clk);
    in_En = 1'b0;
    rst   = 1'b1;
    exp_q.delete();
    lat_q.delete();
    #1;
    check16("midflight_rst_out", out_Out, 16'h0000);
    check16("midflight_rst_ready", {15'h0, out_Ready}, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(6);
    check16("post_reset_out", out_Out, 16'h0000);
    check_int("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
